// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master I2C byte engine with 7-bit addressing.
// Define I2C_MASTER_CTRL_CLK_STRETCH_EN to honour target clock stretching.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             rw_i,
    input  logic [6:0]       addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [7:0]       wdata_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    output logic [7:0]       rdata_o,
    output logic             rdata_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             nack_o,
    output logic             scl_oe_o,
    output logic             sda_oe_o,
    input  logic             scl_i,
    input  logic             sda_i
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WWAIT,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       stp_q, stp_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rw_q, rw_d;
    logic [6:0]       addr_q, addr_d;
    logic             nack_q, nack_d;
    logic             rvalid_q, rvalid_d;

    logic scl_oe_q, scl_oe_d;
    logic sda_oe_q, sda_oe_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic nacko_q, nacko_d;
    logic wready_q, wready_d;

    logic is_bit;
    logic tick;
    logic hold;
    logic adv;
    logic bit_end;

    assign is_bit = (state_q == S_ADDR) || (state_q == S_ADDR_ACK) ||
                    (state_q == S_WDATA) || (state_q == S_WDATA_ACK) ||
                    (state_q == S_RDATA) || (state_q == S_RDATA_ACK);
    assign tick = (cnt_q == CNT_MAX);

`ifdef I2C_MASTER_CTRL_CLK_STRETCH_EN
    // A target holding SCL low freezes the high half until it lets go.
    assign hold = is_bit && phase_q && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold = 1'b0;
`endif

    assign adv     = tick && !hold;
    assign bit_end = is_bit && adv && phase_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        stp_d    = stp_q;
        rem_d    = rem_q;
        sh_d     = sh_q;
        rdata_d  = rdata_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        nack_d   = nack_q;
        rvalid_d = 1'b0;

        if (!hold) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
        if (is_bit && adv) begin
            phase_d = ~phase_q;
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                stp_d   = '0;
                if (start_i) begin
                    rw_d    = rw_i;
                    addr_d  = addr_i;
                    rem_d   = len_i;
                    nack_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (adv) begin
                    sh_d    = {addr_q, rw_q};
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_WDATA: begin
                if (bit_end) begin
                    sh_d  = {sh_q[6:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = (state_q == S_ADDR) ? S_ADDR_ACK
                                                      : S_WDATA_ACK;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (bit_end) begin
                    if (sda_i) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else if (rem_q == '0) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = rw_q ? S_RDATA : S_WWAIT;
                    end
                end
            end
            S_WWAIT: begin
                cnt_d = '0;
                if (wdata_valid_i && wready_q) begin
                    sh_d    = wdata_i;
                    state_d = S_WDATA;
                end
            end
            S_WDATA_ACK: begin
                if (bit_end) begin
                    if (sda_i) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        rem_d   = rem_q - ONE;
                        state_d = (rem_q == ONE) ? S_STOP : S_WWAIT;
                    end
                end
            end
            S_RDATA: begin
                if (bit_end) begin
                    sh_d  = {sh_q[6:0], sda_i};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        rdata_d  = {sh_q[6:0], sda_i};
                        rvalid_d = 1'b1;
                        state_d  = S_RDATA_ACK;
                    end
                end
            end
            S_RDATA_ACK: begin
                if (bit_end) begin
                    rem_d   = rem_q - ONE;
                    state_d = (rem_q == ONE) ? S_STOP : S_RDATA;
                end
            end
            S_STOP: begin
                if (stp_q == 2'd3) begin
                    state_d = S_IDLE;
                end else if (adv) begin
                    stp_d = stp_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from next-state so the registered copy lines up with state_q.
    always_comb begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        wready_d = 1'b0;
        done_d   = 1'b0;
        nacko_d  = 1'b0;
        busy_d   = (state_d != S_IDLE);
        unique case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_START: begin
                sda_oe_d = 1'b1;
            end
            S_ADDR, S_WDATA: begin
                scl_oe_d = ~phase_d;
                sda_oe_d = ~sh_d[7];
            end
            S_ADDR_ACK, S_WDATA_ACK, S_RDATA: begin
                scl_oe_d = ~phase_d;
            end
            S_RDATA_ACK: begin
                scl_oe_d = ~phase_d;
                sda_oe_d = (rem_d != ONE);
            end
            S_WWAIT: begin
                scl_oe_d = 1'b1;
                wready_d = 1'b1;
            end
            S_STOP: begin
                scl_oe_d = (stp_d == 2'd0);
                sda_oe_d = (stp_d < 2'd2);
                done_d   = (stp_d == 2'd3);
                nacko_d  = (stp_d == 2'd3) && nack_d;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            bit_q    <= '0;
            stp_q    <= '0;
            rem_q    <= '0;
            sh_q     <= '0;
            rdata_q  <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            nack_q   <= 1'b0;
            rvalid_q <= 1'b0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            nacko_q  <= 1'b0;
            wready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            stp_q    <= stp_d;
            rem_q    <= rem_d;
            sh_q     <= sh_d;
            rdata_q  <= rdata_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            nack_q   <= nack_d;
            rvalid_q <= rvalid_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            nacko_q  <= nacko_d;
            wready_q <= wready_d;
        end
    end

    assign wdata_ready_o = wready_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign nack_o        = nacko_q;
    assign scl_oe_o      = scl_oe_q;
    assign sda_oe_o      = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: directed checks of i2c_master_ctrl against a bus-level
// target model and expected-bit / expected-byte scoreboards.
`timescale 1ns/1ps
module tb_i2c_master_ctrl;

    localparam int CLK_DIV = 4;
    localparam int LEN_W   = 8;
`ifdef I2C_MASTER_CTRL_CLK_STRETCH_EN
    localparam int STRETCH_HIGH = CLK_DIV + 20;
`else
    localparam int STRETCH_HIGH = CLK_DIV;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             rw_i = 1'b0;
    logic [6:0]       addr_i = '0;
    logic [LEN_W-1:0] len_i = '0;
    logic [7:0]       wdata_i = '0;
    logic             wdata_valid_i = 1'b0;
    logic             wdata_ready_o;
    logic [7:0]       rdata_o;
    logic             rdata_valid_o;
    logic             busy_o;
    logic             done_o;
    logic             nack_o;
    logic             scl_oe_o;
    logic             sda_oe_o;
    logic             scl_i;
    logic             sda_i;

    logic pull = 1'b0;
    logic stretch = 1'b0;
    logic feed_en = 1'b0;
    logic chk_bits = 1'b1;

    bit         exp_bits[$];
    bit         resp[$];
    logic [7:0] exp_rd[$];
    logic [7:0] wq[$];

    int n_tests = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    int stop_cnt = 0;

    assign scl_i = scl_oe_o ? 1'b0 : !stretch;
    assign sda_i = !(sda_oe_o || pull);

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start_i),
        .rw_i(rw_i),
        .addr_i(addr_i),
        .len_i(len_i),
        .wdata_i(wdata_i),
        .wdata_valid_i(wdata_valid_i),
        .wdata_ready_o(wdata_ready_o),
        .rdata_o(rdata_o),
        .rdata_valid_o(rdata_valid_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .nack_o(nack_o),
        .scl_oe_o(scl_oe_o),
        .sda_oe_o(sda_oe_o),
        .scl_i(scl_i),
        .sda_i(sda_i)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus model: write-data feeder, target SDA driver, bit monitor, read scoreboard.
    initial begin
        bit ps, pd, cs, cd, in_bit, hs_pend;
        ps = 1'b1;
        pd = 1'b1;
        in_bit = 1'b0;
        hs_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (hs_pend) begin
                if (wq.size() > 0) void'(wq.pop_front());
                hs_cnt++;
            end
            cs = !scl_oe_o;
            cd = !(sda_oe_o || pull);
            if (ps && cs && pd && !cd) in_bit = 1'b0;
            if (ps && cs && !pd && cd) stop_cnt++;
            if (ps && !cs) begin
                if (in_bit && chk_bits) begin
                    if (exp_bits.size() > 0)
                        check("sda_bit", 32'(pd), 32'(exp_bits.pop_front()));
                    else
                        check("sda_bit_extra", exp_bits.size(), 1);
                end
                in_bit = 1'b0;
                pull = (resp.size() > 0) ? resp.pop_front() : 1'b0;
            end
            if (!ps && cs) in_bit = 1'b1;
            if (!busy_o) pull = 1'b0;
            if (rdata_valid_o) begin
                if (exp_rd.size() > 0)
                    check("rdata", rdata_o, exp_rd.pop_front());
                else
                    check("rdata_extra", exp_rd.size(), 1);
            end
            wdata_valid_i = feed_en && (wq.size() > 0);
            wdata_i = (wq.size() > 0) ? wq[0] : 8'h00;
            hs_pend = wdata_valid_i && wdata_ready_o;
            ps = cs;
            pd = !(sda_oe_o || pull);
        end
    end

    task automatic exp_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
    endtask

    task automatic resp_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) resp.push_back(!b[i]);
    endtask

    task automatic resp_rel(input int n);
        repeat (n) resp.push_back(1'b0);
    endtask

    task automatic do_start(input logic rw, input logic [6:0] a,
                            input logic [LEN_W-1:0] len);
        @(negedge clk);
        start_i = 1'b1;
        rw_i = rw;
        addr_i = a;
        len_i = len;
        @(negedge clk);
        start_i = 1'b0;
        rw_i = 1'b0;
        addr_i = '0;
        len_i = '0;
        check("busy_after_start", busy_o, 1);
    endtask

    task automatic wait_done(input string tag, input logic exp_nack);
        int n;
        n = 0;
        while (!done_o && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done_o, 1);
        check({tag, "_nack"}, nack_o, exp_nack);
        check({tag, "_busy_at_done"}, busy_o, 1);
        @(negedge clk);
        check({tag, "_idle"}, {busy_o, done_o, nack_o, scl_oe_o, sda_oe_o}, 0);
        check({tag, "_bits_left"}, exp_bits.size(), 0);
        check({tag, "_rd_left"}, exp_rd.size(), 0);
    endtask

    initial begin
        int h0, s0, n, bad;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        check("reset_outputs", {scl_oe_o, sda_oe_o, busy_o, done_o, nack_o,
              wdata_ready_o, rdata_valid_o, rdata_o}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // write 0x50, A5 3C, all acked, with a stray start mid-transfer
        exp_byte(8'hA0); exp_bits.push_back(0);
        exp_byte(8'hA5); exp_bits.push_back(0);
        exp_byte(8'h3C); exp_bits.push_back(0);
        resp_rel(8); resp.push_back(1);
        resp_rel(8); resp.push_back(1);
        resp_rel(8); resp.push_back(1);
        wq.push_back(8'hA5); wq.push_back(8'h3C);
        feed_en = 1'b1;
        h0 = hs_cnt; s0 = stop_cnt;
        do_start(1'b0, 7'h50, 8'd2);
        repeat (20) @(negedge clk);
        start_i = 1'b1; rw_i = 1'b1; addr_i = 7'h7F; len_i = 8'd9;
        @(negedge clk);
        start_i = 1'b0; rw_i = 1'b0; addr_i = '0; len_i = '0;
        wait_done("wr2", 1'b0);
        check("wr2_handshakes", hs_cnt - h0, 2);
        check("wr2_stop", stop_cnt - s0, 1);
        feed_en = 1'b0;

        // read 0x21, 3 bytes
        exp_byte(8'h43); exp_bits.push_back(0);
        exp_byte(8'h11); exp_bits.push_back(0);
        exp_byte(8'h22); exp_bits.push_back(0);
        exp_byte(8'h33); exp_bits.push_back(1);
        resp_rel(8); resp.push_back(1);
        resp_byte(8'h11); resp_rel(1);
        resp_byte(8'h22); resp_rel(1);
        resp_byte(8'h33); resp_rel(1);
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
        s0 = stop_cnt;
        do_start(1'b1, 7'h21, 8'd3);
        wait_done("rd3", 1'b0);
        check("rd3_stop", stop_cnt - s0, 1);
        check("rd3_rdata_hold", rdata_o, 8'h33);

        // address-only probe
        exp_byte(8'h43); exp_bits.push_back(0);
        resp_rel(8); resp.push_back(1);
        s0 = stop_cnt;
        do_start(1'b1, 7'h21, 8'd0);
        wait_done("probe", 1'b0);
        check("probe_stop", stop_cnt - s0, 1);

        // address NACK on write len=4
        exp_byte(8'hA0); exp_bits.push_back(1);
        resp_rel(9);
        for (int i = 0; i < 4; i++) wq.push_back(8'(i + 1));
        feed_en = 1'b1;
        h0 = hs_cnt; s0 = stop_cnt;
        do_start(1'b0, 7'h50, 8'd4);
        wait_done("anack", 1'b1);
        check("anack_handshakes", hs_cnt - h0, 0);
        check("anack_stop", stop_cnt - s0, 1);
        feed_en = 1'b0;
        @(negedge clk);
        wq.delete();

        // write stalled 50 cycles in WWAIT
        exp_byte(8'hA0); exp_bits.push_back(0);
        exp_byte(8'h96); exp_bits.push_back(0);
        resp_rel(8); resp.push_back(1);
        resp_rel(8); resp.push_back(1);
        wq.push_back(8'h96);
        h0 = hs_cnt;
        do_start(1'b0, 7'h50, 8'd1);
        n = 0;
        while (!wdata_ready_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("wwait_reached", wdata_ready_o, 1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!scl_oe_o || !wdata_ready_o) bad++;
        end
        check("wwait_scl_hold", bad, 0);
        feed_en = 1'b1;
        wait_done("wwait", 1'b0);
        check("wwait_handshakes", hs_cnt - h0, 1);
        feed_en = 1'b0;

        // reset in the middle of a read byte
        chk_bits = 1'b0;
        resp_rel(8); resp.push_back(1);
        resp_byte(8'hF0); resp_rel(1);
        resp_byte(8'h0F); resp_rel(1);
        do_start(1'b1, 7'h21, 8'd2);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_rdata", {scl_oe_o, sda_oe_o, busy_o, done_o, nack_o,
              wdata_ready_o, rdata_valid_o, rdata_o}, 0);
        rst_n = 1'b1;
        resp.delete();
        exp_bits.delete();
        @(negedge clk);
        check("after_reset_idle", {busy_o, scl_oe_o, sda_oe_o}, 0);
        chk_bits = 1'b1;

        // clean read after reset
        exp_byte(8'h43); exp_bits.push_back(0);
        exp_byte(8'hC3); exp_bits.push_back(1);
        resp_rel(8); resp.push_back(1);
        resp_byte(8'hC3); resp_rel(1);
        exp_rd.push_back(8'hC3);
        do_start(1'b1, 7'h21, 8'd1);
        wait_done("rd_post_reset", 1'b0);

        // target holds SCL low for 20 cycles in the first data-bit high half
        exp_byte(8'hA0); exp_bits.push_back(0);
        exp_byte(8'h5A); exp_bits.push_back(0);
        resp_rel(8); resp.push_back(1);
        resp_rel(8); resp.push_back(1);
        wq.push_back(8'h5A);
        feed_en = 1'b1;
        h0 = hs_cnt;
        do_start(1'b0, 7'h50, 8'd1);
        n = 0;
        while (hs_cnt == h0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        while (scl_oe_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        stretch = 1'b1;
        while (!scl_oe_o && n < 200) begin
            if (n == 20) stretch = 1'b0;
            n++;
            @(negedge clk);
        end
        stretch = 1'b0;
        check("stretch_high_len", n, STRETCH_HIGH);
        wait_done("stretch", 1'b0);
        feed_en = 1'b0;

        // maximum byte count, no wrap
        exp_byte(8'hA0); exp_bits.push_back(0);
        resp_rel(8); resp.push_back(1);
        for (int i = 0; i < 255; i++) begin
            b = 8'(i * 37 + 1);
            exp_byte(b); exp_bits.push_back(0);
            resp_rel(8); resp.push_back(1);
            wq.push_back(b);
        end
        feed_en = 1'b1;
        h0 = hs_cnt;
        do_start(1'b0, 7'h50, 8'd255);
        wait_done("len255", 1'b0);
        check("len255_handshakes", hs_cnt - h0, 255);
        feed_en = 1'b0;

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 250: clk cycles per SCL half-period; legal range >= 4.
REQ-002 Parameter LEN_W, default 8: width of the transfer byte-count.
REQ-003 One clock `clk`; reset `rst_n` is synchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  sync active-low reset
- start_i  in  1  transfer request pulse
- rw_i  in  1  1=read, 0=write
- addr_i  in  7  target address
- len_i  in  LEN_W  byte count
- wdata_i  in  8  write byte
- wdata_valid_i  in  1  write byte valid
- wdata_ready_o  out  1  write byte accepted
- rdata_o  out  8  read byte
- rdata_valid_o  out  1  read byte strobe
- busy_o  out  1  transfer active
- done_o  out  1  end-of-transfer pulse
- nack_o  out  1  NACK flag, valid with done_o
- scl_oe_o  out  1  1=pull SCL low
- sda_oe_o  out  1  1=pull SDA low
- scl_i  in  1  SCL line sense
- sda_i  in  1  SDA line sense

Function
REQ-005 FSM states: IDLE, START, ADDR, ADDR_ACK, WWAIT, WDATA, WDATA_ACK, RDATA, RDATA_ACK, STOP; a half-period counter (0..CLK_DIV-1) paces every state except IDLE and WWAIT.
REQ-006 IDLE: scl_oe_o=0, sda_oe_o=0, busy_o=0; start_i=1 latches rw_i, addr_i and len_i, then enters START next cycle.
REQ-007 start_i while busy_o=1 is ignored; latched values are not disturbed.
REQ-008 START: sda_oe_o=1 with SCL released for CLK_DIV cycles, then ADDR.
REQ-009 Each bit = low half (scl_oe_o=1, SDA driven) + high half (scl_oe_o=0); SDA changes only on the first cycle of the low half.
REQ-010 sda_i is sampled on the last cycle of the high half.
REQ-011 ADDR shifts {addr, rw} MSB-first (8 bits), then ADDR_ACK releases SDA for one bit.
REQ-012 Address NACK (sda_i=1) -> STOP, with nack_o=1 alongside done_o.
REQ-013 len=0 is an address-only probe: after ADDR_ACK -> STOP regardless of rw.
REQ-014 Write path: WWAIT holds scl_oe_o=1 and wdata_ready_o=1; a handshake (wdata_valid_i & wdata_ready_o) loads the byte and enters WDATA next cycle. WWAIT has no timeout.
REQ-015 wdata_ready_o is 1 only in WWAIT.
REQ-016 WDATA shifts 8 bits MSB-first, then WDATA_ACK.
REQ-017 After WDATA_ACK: NACK -> STOP with nack_o=1; else remaining count decrements, then WWAIT if >0, else STOP.
REQ-018 Read path: RDATA releases SDA and samples 8 bits MSB-first.
REQ-019 rdata_valid_o pulses one cycle, with rdata_o, on the cycle the 8th bit is sampled; rdata_o holds until the next pulse.
REQ-020 RDATA_ACK drives ACK (sda_oe_o=1) on every byte except the last, which gets NACK (SDA released); then RDATA, or STOP after the last byte.
REQ-021 STOP sequence, CLK_DIV cycles each:
- SCL low, SDA low
- SCL released, SDA low
- both released
REQ-022 At the end of STOP: done_o pulses one cycle, then IDLE.
REQ-023 busy_o=1 from the cycle after an accepted start_i through the done_o cycle inclusive.
REQ-024 nack_o is 0 except on a done_o cycle.
REQ-025 The remaining-byte counter is LEN_W bits; len_i=2^LEN_W-1 transfers exactly that many bytes with no wrap.

Reset
REQ-026 rst_n=0 at a clk edge forces IDLE, clears counters and the shift register, and drives every output to 0 (including rdata_o=0) on that edge, including mid-transfer; no STOP is generated.

Configuration
REQ-027 Macro I2C_MASTER_CTRL_CLK_STRETCH_EN.
- Defined: in any high half, the half-period counter holds while scl_i=0 (target stretching); counting resumes the cycle after scl_i=1.
- Undefined: scl_i is ignored and the high half always lasts CLK_DIV cycles.

Verification
REQ-028 CLK_DIV=4, write addr=0x50, len=2, bytes 0xA5,0x3C, target ACKs all:
- SDA bit sequence 1010000_0, A, 10100101, A, 00111100, A, then STOP
- two wdata_ready_o handshakes, done_o=1, nack_o=0
REQ-029 Read addr=0x21, len=3, target returns 0x11,0x22,0x33:
- three rdata_valid_o pulses with those values
- controller drives ACK, ACK, NACK
REQ-030 Address NACK on a write, len=4: STOP follows ADDR_ACK, done_o=1 with nack_o=1, zero wdata_ready_o handshakes.
REQ-031 Write with wdata_valid_i held low 50 cycles in WWAIT: scl_oe_o stays 1 throughout; transfer completes normally after valid rises.
REQ-032 rst_n=0 mid-byte in RDATA: next cycle all outputs 0, busy_o=0; a new start_i then yields a clean transfer.
REQ-033 With I2C_MASTER_CTRL_CLK_STRETCH_EN defined and scl_i forced low 20 cycles in a high half: that bit's high half extends by 20 cycles; the data byte is unchanged.
